// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline fetch stage: fetch FSM states,
// PC increment, default prefetch depth and the queue entry layout.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam int          DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, inst}, strict FIFO order, with a
// single-cycle flush that empties the queue on a redirect.
module fetch_fifo
  import arm_pipe_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wr_data,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array is deliberately not reset; occ gates every read,
  // so stale words are never presented as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        occ <= occ + 1'b1;
      end else if (pop && !push) begin
        occ <= occ - 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch unit: keeps one registered request to instruction
// memory in flight and buffers returned words ahead of the IF/ID register.
module fetch_prefetch_unit
  import arm_pipe_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  localparam int              OCC_W     = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      addr_d;
  logic             run_q;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_after;
  logic [31:0]      next_addr;
  logic [31:0]      target_pc;
  logic             push;
  logic             pop;
  fetch_entry_t     wr_entry;
  fetch_entry_t     head;

  assign out_valid = (occ != '0);
  assign pop       = out_valid && !id_stall && !redirect_valid;
  assign push      = (state_q == FETCH_REQ) && imem_ack && !redirect_valid;
  assign occ_after = occ + 1'b1 - {{(OCC_W-1){1'b0}}, pop};
  assign next_addr = imem_addr + PC_STEP;
  assign target_pc = word_align(redirect_pc);

  assign wr_entry.pc   = imem_addr;
  assign wr_entry.inst = imem_rdata;
  assign out_pc        = head.pc;
  assign out_inst      = head.inst;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = imem_addr;
    unique case (state_q)
      FETCH_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc;
          addr_d     = target_pc;
          state_d    = FETCH_REQ;
        end else if (run_q && occ < DEPTH_OCC) begin
          addr_d  = fetch_pc_q;
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc;
          if (imem_ack) begin
            addr_d = target_pc;
          end else begin
            state_d = FETCH_DRAIN;
          end
        end else if (imem_ack) begin
          fetch_pc_d = next_addr;
          if (occ_after < DEPTH_OCC) begin
            addr_d = next_addr;
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end
      FETCH_DRAIN: begin
        // The in-flight word belongs to the old path; only the target moves.
        if (redirect_valid) begin
          fetch_pc_d = target_pc;
        end
        if (imem_ack) begin
          addr_d  = redirect_valid ? target_pc : fetch_pc_q;
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  // run_q delays the very first request by one cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= word_align(RESET_PC);
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      imem_req   <= (state_d != FETCH_IDLE);
      imem_addr  <= addr_d;
      run_q      <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .rd_data (head),
    .occ     (occ)
  );

endmodule

// File: doc/fetch_prefetch_unit.md
FETCH_PREFETCH_UNIT -- requirements
Module: fetch_prefetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch queue entry count; legal values are powers of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 redirect_valid  input  1  branch taken / PC write from execute; flushes the queue.
REQ-006 redirect_pc  input  32  new fetch address; sampled only when redirect_valid=1.
REQ-007 id_stall  input  1  IF/ID register not writing this cycle; head SHALL NOT be consumed.
REQ-008 out_valid  output  1  queue head holds a valid instruction for IF/ID.
REQ-009 out_pc  output  32  fetch address of head instruction.
REQ-010 out_inst  output  32  head instruction word.
REQ-011 imem_req  output  1  instruction memory request, registered.
REQ-012 imem_addr  output  32  request address, registered, word aligned.
REQ-013 imem_ack  input  1  memory accepts request and returns data in the same cycle.
REQ-014 imem_rdata  input  32  instruction word, valid when imem_ack=1.

Function
REQ-015 FSM states IDLE, REQ, DRAIN; IDLE = no request outstanding, REQ = live request, DRAIN = request outstanding whose data SHALL be discarded.
REQ-016 Once imem_req=1, imem_req and imem_addr SHALL stay constant until the cycle imem_ack=1, including across redirect.
REQ-017 Handshake completes in the cycle imem_req=1 and imem_ack=1; imem_ack while imem_req=0 SHALL be ignored.
REQ-018 IDLE -> REQ when occ < DEPTH and redirect_valid=0; imem_addr <= fetch_pc.
REQ-019 REQ with ack and no redirect: push {imem_addr, imem_rdata}; fetch_pc <= imem_addr+4 (mod 2^32); stay in REQ with imem_addr <= imem_addr+4 if (occ+1-pop) < DEPTH, else -> IDLE.
REQ-020 REQ with redirect_valid and no ack -> DRAIN; queue flushed; fetch_pc <= redirect_pc.
REQ-021 REQ with redirect_valid and ack same cycle: data discarded, queue flushed, -> REQ with imem_addr <= redirect_pc.
REQ-022 IDLE with redirect_valid: queue flushed, fetch_pc <= redirect_pc, -> REQ next cycle with imem_addr <= redirect_pc.
REQ-023 DRAIN with ack -> REQ with imem_addr <= fetch_pc, no push; further redirect in DRAIN updates fetch_pc only.
REQ-024 Redirect latency: redirect at cycle N, idle memory, ack at N+1 -> out_valid=1 at N+2 with out_pc=redirect_pc.
REQ-025 out_valid = (occ != 0); out_pc/out_inst = head entry, combinational from storage.
REQ-026 Pop when out_valid=1 and id_stall=0 and redirect_valid=0; redirect SHALL take priority over pop and push.
REQ-027 Push and pop in the same cycle SHALL leave occ unchanged; push when full SHALL never occur (guaranteed by REQ-018/019).
REQ-028 Queue order strictly FIFO; read/write pointers wrap modulo DEPTH; occ width clog2(DEPTH)+1.

Reset
REQ-029 On reset: state=IDLE, occ=0, pointers=0, fetch_pc=RESET_PC, imem_req=0, imem_addr=0, out_valid=0.
REQ-030 First imem_req SHALL assert on the second rising edge after reset deasserts, address RESET_PC.
REQ-031 Reset asserted mid-request SHALL drop imem_req immediately; a pending ack SHALL be ignored.

Structure
REQ-032 Shared package arm_pipe_pkg SHALL hold the fetch state enum, PC_STEP=4, and the default DEPTH constant.
REQ-033 Storage SHALL be a sub-module fetch_fifo (DEPTH x 64 bits, push/pop/flush, occ output); FSM and PC logic stay in the top.

Verification
REQ-034 Reset, ack tied 1, id_stall=0 -> imem_addr 0,4,8,... back-to-back; out_pc 0,4,8 on consecutive cycles from cycle 3.
REQ-035 id_stall=1 held, ack=1 -> exactly 4 pushes (addr 0..C), then imem_req=0; release stall -> fetch resumes at 0x10.
REQ-036 Ack held 0 for 3 cycles with req at 0x8 -> imem_addr stays 0x8, out_valid falls as queue drains.
REQ-037 Redirect to 0x100 while request 0x20 outstanding, ack 2 cycles later -> 0x20 data never appears; next request 0x100.
REQ-038 Redirect to 0x200 coincident with ack and pop -> queue empty next cycle, imem_addr=0x200, no stale out_valid.
REQ-039 Async reset pulse mid-REQ -> imem_req=0 and out_valid=0 same cycle; restart at RESET_PC.
